instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Instruction-memory stage directly upstream of the 8-bit CPU core.
- Holds a switch-programmable instruction RAM and serves `instruction` combinationally for the CPU's `readingAddress`.
- Sequences load and run modes, and holds the CPU in reset while the program is being entered.
- Replaces the hard-wired instruction ROM on the board build.

Parameters:
- DEPTH, 32, number of 8-bit instruction words (power of two, ≤256)
- ADDR_W, 5, log2(DEPTH)
- FILL_INSTR, 8'h00, value of every word after reset/clear and for out-of-range reads
- DEBOUNCE_CYCLES, 20'd500000, cycles a button must stay high to count as one press
- RESTART_CYCLES, 2, cycles `cpuReset` stays high after leaving load mode

Ports:
- CLK  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- loadMode  in  1  switch; 1 = program-entry mode (asynchronous, synchronised internally)
- dataIn  in  8  instruction byte from switches
- writeBtn  in  1  raw push button; one debounced press writes dataIn
- clearBtn  in  1  raw push button; one debounced press clears memory
- readingAddress  in  8  PC from CPU
- instruction  out  8  word fed to CPU
- cpuReset  out  1  active-high reset to CPU core
- wordCount  out  ADDR_W+1  number of words written since entering load mode
- fullLED  out  1  wordCount == DEPTH
- loadingLED  out  1  high in LOAD state

Behaviour:
- Reset (reset=0, async), all of the following apply:
  - state=RESTART, restart counter = 0
  - every memory word = FILL_INSTR
  - wordCount = 0, fullLED = 0, loadingLED = 0
  - cpuReset = 1
  - synchroniser and debounce flops = 0
- Input conditioning:
  - loadMode, writeBtn and clearBtn each pass a 2-flop synchroniser.
  - Per button: a counter increments while the synced level is 1 and clears on any 0.
  - When the counter reaches DEBOUNCE_CYCLES it emits exactly one 1-cycle pulse, then saturates.
  - No further pulse until the level returns to 0 (re-arm).
- State machine:
  - RUN: cpuRun state; cpuReset = 0.
    - Synced loadMode = 1 → LOAD; on entry wordCount = 0, fullLED = 0.
  - LOAD: cpuReset = 1, loadingLED = 1.
    - Write pulse with wordCount < DEPTH: mem[wordCount] <= dataIn sampled in the pulse cycle, wordCount + 1. Visible next cycle.
    - Write pulse with wordCount == DEPTH: ignored. No wrap, no overwrite of word 0.
    - Clear pulse: all words = FILL_INSTR and wordCount = 0 in one cycle.
    - Clear and write pulses in the same cycle: clear wins, write discarded.
    - Synced loadMode = 0 → RESTART.
  - RESTART: cpuReset = 1 for RESTART_CYCLES cycles, then → RUN.
    - loadMode returning to 1 during RESTART → LOAD, restart counter reset, wordCount cleared.
- Read path (combinational, zero latency):
  - instruction = mem[readingAddress[ADDR_W-1:0]] when readingAddress < DEPTH.
  - Otherwise instruction = FILL_INSTR.
  - Same rule in every state; the CPU is held in reset outside RUN, so this is harmless.
- Write/read same word in the same cycle: read returns the old value.
- Button pulses outside LOAD are discarded.
- wordCount holds its value in RUN/RESTART until the next entry to LOAD.
- Async reset mid-load: all memory reverts to FILL_INSTR, and the CPU is held via RESTART.

Decomposition:
- Shared package (cpu_pkg):
  - INSTR_W = 8
  - state encoding ST_RUN = 2'd0, ST_LOAD = 2'd1, ST_RESTART = 2'd2
  - FILL_INSTR default
- Sub-module `btn_debounce`:
  - one instance per button
  - contains the synchroniser and debounce counter
  - parameter DEBOUNCE_CYCLES
  - ports CLK, reset, btnRaw, pulse
- loadMode uses a bare 2-flop synchroniser in the top.

Test Plan (DEBOUNCE_CYCLES=4, DEPTH=32, RESTART_CYCLES=2):
- Reset release → cpuReset = 1 for 2 cycles then 0; instruction = 8'h00 for readingAddress 0..31 and 8'hFF; wordCount = 0.
- loadMode=1; press writeBtn for 6 cycles with dataIn = 8'h44, 8'h49, 8'h19, 8'h84 in turn → wordCount = 4, one write per press; loadMode=0; after RESTART, readingAddress 0..3 yields 44, 49, 19, 84 and address 4 yields 00.
- writeBtn high for 3 cycles only, and a bouncing 1-0-1 pattern → no write, wordCount unchanged.
- Write 33 presses in LOAD → wordCount = 32, fullLED = 1, 33rd press ignored, word 0 keeps the first value.
- Clear and write pulses in the same cycle after 3 loaded words → all words 00, wordCount = 0, dataIn not stored.
- Assert reset low mid-LOAD and asynchronously between edges → outputs take their reset values immediately, memory all 00, then RESTART→RUN after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-memory stage feeding the 8-bit CPU core.
package cpu_pkg;

  localparam int INSTR_W = 8;
  localparam logic [INSTR_W-1:0] FILL_INSTR_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RESTART = 2'd2
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Synchronises a raw push button and emits one 1-cycle pulse per debounced press.
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic CLK,
  input  logic reset,
  input  logic btnRaw,
  output logic pulse
);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [19:0] cnt_q, cnt_d;
  logic        pulse_q, pulse_d;

  always_comb begin
    sync1_d = btnRaw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q < DEBOUNCE_CYCLES) begin
      cnt_d = cnt_q + 20'd1;
      // Fires only on the step that reaches the threshold; saturation re-arms on a low level.
      pulse_d = (cnt_q == DEBOUNCE_CYCLES - 20'd1);
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/instr_loader.sv
// Switch-programmable instruction RAM with load/restart/run sequencing for the CPU core.
module instr_loader
  import cpu_pkg::*;
#(
  parameter int                 DEPTH           = 32,
  parameter int                 ADDR_W          = 5,
  parameter logic [INSTR_W-1:0] FILL_INSTR      = FILL_INSTR_DEFAULT,
  parameter logic [19:0]        DEBOUNCE_CYCLES = 20'd500000,
  parameter int                 RESTART_CYCLES  = 2
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 loadMode,
  input  logic [INSTR_W-1:0]   dataIn,
  input  logic                 writeBtn,
  input  logic                 clearBtn,
  input  logic [7:0]           readingAddress,
  output logic [INSTR_W-1:0]   instruction,
  output logic                 cpuReset,
  output logic [ADDR_W:0]      wordCount,
  output logic                 fullLED,
  output logic                 loadingLED
);

  localparam int RC_W = (RESTART_CYCLES < 2) ? 1 : $clog2(RESTART_CYCLES);

  logic                 ld_sync1_q, ld_sync1_d;
  logic                 ld_sync2_q, ld_sync2_d;
  state_t               state_q, state_d;
  logic [RC_W-1:0]      rcnt_q, rcnt_d;
  logic [ADDR_W:0]      wc_q, wc_d;
  logic [INSTR_W-1:0]   mem_q [DEPTH];
  logic [INSTR_W-1:0]   mem_d [DEPTH];
  logic                 wr_pulse, clr_pulse;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_wr_db (
    .CLK    (CLK),
    .reset  (reset),
    .btnRaw (writeBtn),
    .pulse  (wr_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .CLK    (CLK),
    .reset  (reset),
    .btnRaw (clearBtn),
    .pulse  (clr_pulse)
  );

  always_comb begin
    ld_sync1_d = loadMode;
    ld_sync2_d = ld_sync1_q;
    state_d    = state_q;
    rcnt_d     = rcnt_q;
    wc_d       = wc_q;
    mem_d      = mem_q;
    cpuReset   = 1'b1;
    loadingLED = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        cpuReset = 1'b0;
        if (ld_sync2_q) begin
          state_d = ST_LOAD;
          wc_d    = '0;
        end
      end
      ST_LOAD: begin
        loadingLED = 1'b1;
        // Clear dominates a coincident write so a clear never leaves a stray word behind.
        if (clr_pulse) begin
          mem_d = '{default: FILL_INSTR};
          wc_d  = '0;
        end else if (wr_pulse && (wc_q < (ADDR_W+1)'(DEPTH))) begin
          mem_d[wc_q[ADDR_W-1:0]] = dataIn;
          wc_d = wc_q + 1'b1;
        end
        if (!ld_sync2_q) begin
          state_d = ST_RESTART;
          rcnt_d  = '0;
        end
      end
      ST_RESTART: begin
        if (ld_sync2_q) begin
          state_d = ST_LOAD;
          rcnt_d  = '0;
          wc_d    = '0;
        end else if (rcnt_q == RC_W'(RESTART_CYCLES - 1)) begin
          state_d = ST_RUN;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RESTART;
        rcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ld_sync1_q <= 1'b0;
      ld_sync2_q <= 1'b0;
      state_q    <= ST_RESTART;
      rcnt_q     <= '0;
      wc_q       <= '0;
      mem_q      <= '{default: FILL_INSTR};
    end else begin
      ld_sync1_q <= ld_sync1_d;
      ld_sync2_q <= ld_sync2_d;
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      wc_q       <= wc_d;
      mem_q      <= mem_d;
    end
  end

  // Out-of-range PCs read as the fill word rather than aliasing into the array.
  always_comb begin
    instruction = FILL_INSTR;
    if ({1'b0, readingAddress} < 9'(DEPTH)) begin
      instruction = mem_q[readingAddress[ADDR_W-1:0]];
    end
  end

  assign wordCount = wc_q;
  assign fullLED   = (wc_q == (ADDR_W+1)'(DEPTH));

endmodule

// File: tb/tb_instr_loader.sv
// Directed, table-driven bench for instr_loader with a short debounce window.
module tb_instr_loader;

  logic       CLK;
  logic       reset;
  logic       loadMode;
  logic [7:0] dataIn;
  logic       writeBtn;
  logic       clearBtn;
  logic [7:0] readingAddress;
  logic [7:0] instruction;
  logic       cpuReset;
  logic [5:0] wordCount;
  logic       fullLED;
  logic       loadingLED;

  int errors = 0;
  int checks = 0;

  instr_loader #(
    .DEPTH           (32),
    .ADDR_W          (5),
    .FILL_INSTR      (8'h00),
    .DEBOUNCE_CYCLES (20'd4),
    .RESTART_CYCLES  (2)
  ) dut (
    .CLK            (CLK),
    .reset          (reset),
    .loadMode       (loadMode),
    .dataIn         (dataIn),
    .writeBtn       (writeBtn),
    .clearBtn       (clearBtn),
    .readingAddress (readingAddress),
    .instruction    (instruction),
    .cpuReset       (cpuReset),
    .wordCount      (wordCount),
    .fullLED        (fullLED),
    .loadingLED     (loadingLED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    int         hi_cycles;
    logic [5:0] exp_wc;
  } press_vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp_instr;
  } rd_vec_t;

  press_vec_t press_tab [5];
  rd_vec_t    rd_tab    [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic press_write(input logic [7:0] d, input int hi);
    dataIn   = d;
    writeBtn = 1'b1;
    step(hi);
    writeBtn = 1'b0;
    step(6);
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [7:0] e);
    readingAddress = a;
    #1;
    check(name, {24'h0, instruction}, {24'h0, e});
  endtask

  initial begin
    press_tab[0] = '{8'h44, 6, 6'd1};
    press_tab[1] = '{8'h49, 6, 6'd2};
    press_tab[2] = '{8'h19, 6, 6'd3};
    press_tab[3] = '{8'h84, 6, 6'd4};
    press_tab[4] = '{8'hAA, 3, 6'd4};

    rd_tab[0] = '{8'h00, 8'h44};
    rd_tab[1] = '{8'h01, 8'h49};
    rd_tab[2] = '{8'h02, 8'h19};
    rd_tab[3] = '{8'h03, 8'h84};
    rd_tab[4] = '{8'h04, 8'h00};
    rd_tab[5] = '{8'h1F, 8'h00};
    rd_tab[6] = '{8'h20, 8'h00};
    rd_tab[7] = '{8'hFF, 8'h00};

    reset = 1'b0; loadMode = 1'b0; dataIn = 8'h00;
    writeBtn = 1'b0; clearBtn = 1'b0; readingAddress = 8'h00;
    step(3);
    check("rst_cpuReset", {31'h0, cpuReset}, 32'd1);
    check("rst_wordCount", {26'h0, wordCount}, 32'd0);
    check("rst_fullLED", {31'h0, fullLED}, 32'd0);
    check("rst_loadingLED", {31'h0, loadingLED}, 32'd0);

    // Restart sequence after release: two held cycles, then run.
    reset = 1'b1;
    step(1);
    check("restart_cyc1", {31'h0, cpuReset}, 32'd1);
    step(1);
    check("restart_run", {31'h0, cpuReset}, 32'd0);
    for (int a = 0; a < 32; a++) read_check("init_read", 8'(a), 8'h00);
    read_check("init_read_ff", 8'hFF, 8'h00);

    loadMode = 1'b1;
    step(4);
    check("load_led", {31'h0, loadingLED}, 32'd1);
    check("load_cpuReset", {31'h0, cpuReset}, 32'd1);
    check("load_wc0", {26'h0, wordCount}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      press_write(press_tab[i].data, press_tab[i].hi_cycles);
      check("press_wc", {26'h0, wordCount}, {26'h0, press_tab[i].exp_wc});
    end

    // Bouncing press: the low glitch restarts the count, neither burst is long enough.
    dataIn = 8'hBB;
    writeBtn = 1'b1; step(3);
    writeBtn = 1'b0; step(1);
    writeBtn = 1'b1; step(3);
    writeBtn = 1'b0; step(6);
    check("bounce_wc", {26'h0, wordCount}, 32'd4);

    loadMode = 1'b0;
    step(8);
    check("run_cpuReset", {31'h0, cpuReset}, 32'd0);
    check("run_loadingLED", {31'h0, loadingLED}, 32'd0);
    check("run_wc_hold", {26'h0, wordCount}, 32'd4);
    for (int i = 0; i < 8; i++) read_check("prog_read", rd_tab[i].addr, rd_tab[i].exp_instr);

    press_write(8'h77, 6);
    check("run_press_wc", {26'h0, wordCount}, 32'd4);
    read_check("run_press_mem", 8'h04, 8'h00);

    // Fill to capacity, then one extra press must be dropped.
    loadMode = 1'b1;
    step(6);
    check("reentry_wc0", {26'h0, wordCount}, 32'd0);
    for (int i = 0; i < 33; i++) press_write(8'h10 + 8'(i), 6);
    check("full_wc", {26'h0, wordCount}, 32'd32);
    check("full_led", {31'h0, fullLED}, 32'd1);
    read_check("full_word0", 8'h00, 8'h10);
    read_check("full_word31", 8'h1F, 8'h2F);

    clearBtn = 1'b1; step(6); clearBtn = 1'b0; step(6);
    check("clear_wc", {26'h0, wordCount}, 32'd0);
    check("clear_full", {31'h0, fullLED}, 32'd0);
    read_check("clear_word0", 8'h00, 8'h00);
    read_check("clear_word31", 8'h1F, 8'h00);

    press_write(8'hA1, 6);
    press_write(8'hA2, 6);
    press_write(8'hA3, 6);
    check("pre_both_wc", {26'h0, wordCount}, 32'd3);
    dataIn = 8'h5A;
    writeBtn = 1'b1; clearBtn = 1'b1;
    step(6);
    writeBtn = 1'b0; clearBtn = 1'b0;
    step(6);
    check("both_wc", {26'h0, wordCount}, 32'd0);
    read_check("both_word0", 8'h00, 8'h00);
    read_check("both_word1", 8'h01, 8'h00);
    read_check("both_word2", 8'h02, 8'h00);

    // Pulse cycle reads the old word; the write is visible one edge later.
    readingAddress = 8'h00;
    dataIn = 8'h66;
    writeBtn = 1'b1;
    step(6);
    check("pulse_cycle_old", {24'h0, instruction}, 32'h00);
    step(1);
    check("after_write_new", {24'h0, instruction}, 32'h66);
    writeBtn = 1'b0;
    step(6);
    check("single_wc", {26'h0, wordCount}, 32'd1);

    // Asynchronous reset between edges while loading.
    @(posedge CLK);
    #3;
    reset = 1'b0;
    loadMode = 1'b0;
    #1;
    check("async_cpuReset", {31'h0, cpuReset}, 32'd1);
    check("async_loadingLED", {31'h0, loadingLED}, 32'd0);
    check("async_wc", {26'h0, wordCount}, 32'd0);
    check("async_mem0", {24'h0, instruction}, 32'h00);
    step(2);
    reset = 1'b1;
    step(1);
    check("async_restart", {31'h0, cpuReset}, 32'd1);
    step(1);
    check("async_run", {31'h0, cpuReset}, 32'd0);
    read_check("async_mem0_run", 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
